deadtime_bank_controller: RTL

Supervisory sequencer for a bank of N dead-time generator channels in the PWM chain. It owns each channel's dead-time value and enable, runs the start-up sequence (bootstrap precharge, arm, run), and applies stop and fault shutdown. New dead-time values are committed only on PWM period boundaries, so no channel sees a mid-period change. It sits between the control register interface and the per-leg dead-time generators, and gates their final outputs.

---
 rtl/deadtime_bank_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/deadtime_bank_controller.sv
// Dead-time bank supervisor: start-up sequencing, shutdown gating and sync-aligned dead-time commits.
// Build option: DEADTIME_PRECHARGE_EN adds the bootstrap PRECHARGE state and its counter.
module deadtime_bank_controller #(
  parameter int N_CHANNELS = 3,
  parameter int DT_WIDTH = 16,
  parameter int PRECHARGE_WIDTH = 16,
  parameter logic [DT_WIDTH-1:0] DEFAULT_DT = DT_WIDTH'(50),
  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic fault,
  input  logic fault_clear,
  input  logic sync,
  input  logic [PRECHARGE_WIDTH-1:0] precharge_cycles,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [CH_W-1:0] cfg_channel,
  input  logic [DT_WIDTH-1:0] cfg_deadtime,
  output logic cfg_error,
  output logic [N_CHANNELS-1:0] dt_enable,
  output logic [N_CHANNELS*DT_WIDTH-1:0] dt_value,
  output logic [N_CHANNELS-1:0] mask_a,
  output logic [N_CHANNELS-1:0] mask_b,
  output logic [2:0] state,
  output logic fault_latched
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRECHARGE = 3'd1;
  localparam logic [2:0] S_ARMED     = 3'd2;
  localparam logic [2:0] S_RUNNING   = 3'd3;
  localparam logic [2:0] S_STOPPING  = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic [N_CHANNELS-1:0] en_d;
  logic [N_CHANNELS-1:0] ma_d;
  logic [N_CHANNELS-1:0] mb_d;

  logic pending;
  logic [CH_W-1:0] sh_ch;
  logic [DT_WIDTH-1:0] sh_dt;
  logic [DT_WIDTH-1:0] active [N_CHANNELS];

  logic hs;
  logic ch_ok;
  logic sync_dom;
  logic commit;

`ifdef DEADTIME_PRECHARGE_EN
  logic [PRECHARGE_WIDTH-1:0] pc_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_cnt <= '0;
    end else if (state_q == S_IDLE && state_d == S_PRECHARGE) begin
      pc_cnt <= (precharge_cycles == '0) ? PRECHARGE_WIDTH'(1)
                                         : precharge_cycles;
    end else if (state_q == S_PRECHARGE) begin
      pc_cnt <= pc_cnt - PRECHARGE_WIDTH'(1);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^precharge_cycles;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // fault outranks everything, then stop, then start
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!stop && start) begin
`ifdef DEADTIME_PRECHARGE_EN
            state_d = S_PRECHARGE;
`else
            state_d = S_ARMED;
`endif
          end
        end
`ifdef DEADTIME_PRECHARGE_EN
        S_PRECHARGE: begin
          if (stop)                             state_d = S_IDLE;
          else if (pc_cnt <= PRECHARGE_WIDTH'(1)) state_d = S_ARMED;
        end
`endif
        S_ARMED: begin
          if (stop)      state_d = S_IDLE;
          else if (sync) state_d = S_RUNNING;
        end
        S_RUNNING:  if (stop) state_d = S_STOPPING;
        S_STOPPING: if (sync) state_d = S_IDLE;
        S_FAULT:    if (fault_clear) state_d = S_IDLE;
        default:    state_d = S_FAULT;
      endcase
    end
  end

  always_comb begin
    en_d = '0;
    ma_d = '0;
    mb_d = '0;
    unique case (1'b1)
      (state_d == S_RUNNING),
      (state_d == S_STOPPING): begin
        en_d = '1;
        ma_d = '1;
        mb_d = '1;
      end
      (state_d == S_PRECHARGE): mb_d = '1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dt_enable     <= '0;
      mask_a        <= '0;
      mask_b        <= '0;
      fault_latched <= 1'b0;
    end else begin
      dt_enable     <= en_d;
      mask_a        <= ma_d;
      mask_b        <= mb_d;
      fault_latched <= (state_d == S_FAULT);
    end
  end

  assign state     = state_q;
  assign cfg_ready = ~pending;

  assign hs       = cfg_valid & ~pending;
  assign ch_ok    = int'(cfg_channel) < N_CHANNELS;
  assign sync_dom = (state_q == S_ARMED) || (state_q == S_RUNNING) ||
                    (state_q == S_STOPPING);
  // outside the gated states nothing is switching, so commit at once
  assign commit   = pending & (~sync_dom | sync);

  always_ff @(posedge clock) begin
    if (reset) begin
      pending   <= 1'b0;
      cfg_error <= 1'b0;
      sh_ch     <= '0;
      sh_dt     <= DEFAULT_DT;
      for (int k = 0; k < N_CHANNELS; k++) active[k] <= DEFAULT_DT;
    end else begin
      cfg_error <= hs & ~ch_ok;
      if (commit) begin
        active[sh_ch] <= sh_dt;
        pending       <= 1'b0;
      end
      if (hs && ch_ok) begin
        pending <= 1'b1;
        sh_ch   <= cfg_channel;
        sh_dt   <= (cfg_deadtime == '0) ? DT_WIDTH'(1) : cfg_deadtime;
      end
    end
  end

  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_dt
    assign dt_value[k*DT_WIDTH +: DT_WIDTH] = active[k];
  end

endmodule
